// File: rtl/gray2rgb_serializer_pkg.sv
// Shared constants for the gray-to-RGB output serializer: default pixel width,
// colour-channel encoding and FSM state encoding.
package gray2rgb_serializer_pkg;

  localparam int COLOR_SIZE_DEF = 8;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_R    = 2'd1;
  localparam logic [1:0] S_G    = 2'd2;
  localparam logic [1:0] S_B    = 2'd3;

endpackage

// File: rtl/gray2rgb_serializer_sync_fifo.sv
// Small synchronous FIFO with registered occupancy count; head is read
// combinationally. Synchronous active-low reset plus active-high clear.
module sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign full_o  = (count == (AW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign dout_o  = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && rst_i && !clear_i) mem[wr_ptr] <= din_i;
  end

endmodule

// File: rtl/gray2rgb_serializer.sv
// Re-expands buffered gray pixels into three colour-channel beats (R, G, B)
// carrying the gray value, and counts pixels emitted per frame.
module gray2rgb_serializer
  import gray2rgb_serializer_pkg::*;
#(
  parameter int COLOR_SIZE = COLOR_SIZE_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  gray_valid_i,
  output logic                  gray_ready_o,
  input  logic [COLOR_SIZE-1:0] gray_data_i,
  input  logic                  gray_last_i,
  output logic                  rgb_valid_o,
  input  logic                  rgb_ready_i,
  output logic [COLOR_SIZE-1:0] rgb_data_o,
  output logic [1:0]            rgb_channel_o,
  output logic                  rgb_last_o,
  output logic [CNT_W-1:0]      pix_count_o,
  output logic                  frame_done_o,
  output logic [1:0]            dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Once valid is raised it stays high, and the payload stays constant,
  // until that transfer; ready never depends combinationally on valid.

  logic [1:0]          state;
  logic                pix_last;
  logic                fifo_full;
  logic                fifo_empty;
  logic [COLOR_SIZE:0] fifo_dout;
  logic                push;
  logic                pop;
  logic                beat_acc;
  logic                b_acc;

  assign gray_ready_o = !fifo_full;
  assign push         = gray_valid_i && gray_ready_o;
  assign rgb_valid_o  = (state != S_IDLE);
  assign beat_acc     = rgb_valid_o && rgb_ready_i;
  assign b_acc        = beat_acc && (state == S_B);
  // Pull the next pixel when idle, or back-to-back as the B beat leaves.
  assign pop          = !fifo_empty && ((state == S_IDLE) || b_acc);
  assign dbg_state_o  = state;

  sync_fifo #(
    .WIDTH (COLOR_SIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({gray_last_i, gray_data_i}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      state         <= S_IDLE;
      rgb_data_o    <= '0;
      rgb_channel_o <= CH_R;
      rgb_last_o    <= 1'b0;
      pix_last      <= 1'b0;
      pix_count_o   <= '0;
      frame_done_o  <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (b_acc) begin
        if (rgb_last_o) begin
          pix_count_o  <= '0;
          frame_done_o <= 1'b1;
        end else begin
          pix_count_o <= pix_count_o + CNT_W'(1);
        end
      end

      if (pop) begin
        state         <= S_R;
        rgb_data_o    <= fifo_dout[COLOR_SIZE-1:0];
        pix_last      <= fifo_dout[COLOR_SIZE];
        rgb_channel_o <= CH_R;
        rgb_last_o    <= 1'b0;
      end else begin
        case (state)
          S_R: if (beat_acc) begin
            state         <= S_G;
            rgb_channel_o <= CH_G;
          end
          S_G: if (beat_acc) begin
            state         <= S_B;
            rgb_channel_o <= CH_B;
            rgb_last_o    <= pix_last;
          end
          S_B: if (beat_acc) begin
            state         <= S_IDLE;
            rgb_channel_o <= CH_R;
            rgb_last_o    <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gray2rgb_serializer.sv
// Bench for gray2rgb_serializer: occupancy/beat-queue model checked every cycle,
// directed literal checks for the key scenarios, then randomized traffic.
module tb_gray2rgb_serializer;

  localparam int CW    = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;
  localparam int BW    = CW + 3;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             clear_i;
  logic             gray_valid_i;
  logic             gray_ready_o;
  logic [CW-1:0]    gray_data_i;
  logic             gray_last_i;
  logic             rgb_valid_o;
  logic             rgb_ready_i;
  logic [CW-1:0]    rgb_data_o;
  logic [1:0]       rgb_channel_o;
  logic             rgb_last_o;
  logic [CNT_W-1:0] pix_count_o;
  logic             frame_done_o;
  logic [1:0]       dbg_state_o;

  gray2rgb_serializer #(
    .COLOR_SIZE (CW),
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .clear_i       (clear_i),
    .gray_valid_i  (gray_valid_i),
    .gray_ready_o  (gray_ready_o),
    .gray_data_i   (gray_data_i),
    .gray_last_i   (gray_last_i),
    .rgb_valid_o   (rgb_valid_o),
    .rgb_ready_i   (rgb_ready_i),
    .rgb_data_o    (rgb_data_o),
    .rgb_channel_o (rgb_channel_o),
    .rgb_last_o    (rgb_last_o),
    .pix_count_o   (pix_count_o),
    .frame_done_o  (frame_done_o),
    .dbg_state_o   (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // downstream ready generation: 0 = fixed, 1 = random, 2 = pattern 1,0,0
  int   ready_mode = 0;
  logic ready_fix  = 1'b0;
  logic ready_gen  = 1'b0;
  int   pat_i      = 0;
  assign rgb_ready_i = (ready_mode == 0) ? ready_fix : ready_gen;

  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) ready_gen = ($urandom_range(0, 1) == 1);
    else if (ready_mode == 2) begin
      ready_gen = ((pat_i % 3) == 0);
      pat_i++;
    end
  end

  // scoreboard: beats {last, channel, data} still owed downstream
  logic [BW-1:0]    exp_q[$];
  int               fifo_n  = 0;
  bit               held    = 0;
  logic [CNT_W-1:0] cnt_m   = '0;
  bit               done_m  = 0;
  bit               armed   = 0;
  bit               prev_stall = 0;
  logic [BW-1:0]    prev_beat;
  bit               rec_en  = 0;
  logic [9:0]       obs_q[$];
  int               done_pulses = 0;
  int               last_beats  = 0;
  logic [BW-1:0]    last_beat_seen = '0;

  always @(negedge clk) begin
    logic [BW-1:0] act;
    logic [BW-1:0] head;
    bit acc, b_acc, pop, push;
    act  = {rgb_last_o, rgb_channel_o, rgb_data_o};
    head = (exp_q.size() > 0) ? exp_q[0] : '1;
    if (armed) begin
      check("valid", rgb_valid_o, held);
      check("gray_ready", gray_ready_o, (fifo_n < DEPTH));
      check("pix_count", pix_count_o, cnt_m);
      check("frame_done", frame_done_o, done_m);
      if (held) begin
        check("beat", act, head);
        if (prev_stall) check("stall_stable", act, prev_beat);
      end
      if (rec_en && frame_done_o) done_pulses++;
    end
    if (!rst_i || clear_i) begin
      exp_q.delete();
      fifo_n = 0; held = 0; cnt_m = '0; done_m = 0; prev_stall = 0;
      armed = 1;
    end else if (armed) begin
      acc    = held && rgb_ready_i;
      b_acc  = acc && (head[9:8] == 2'd2);
      done_m = b_acc && head[10];
      if (b_acc) cnt_m = head[10] ? '0 : cnt_m + 1'b1;
      if (acc) begin
        if (rec_en) begin
          obs_q.push_back(act[9:0]);
          if (rgb_last_o) begin
            last_beats++;
            last_beat_seen = act;
          end
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      prev_stall = held && !rgb_ready_i;
      prev_beat  = act;
      pop  = (fifo_n > 0) && (!held || b_acc);
      push = gray_valid_i && (fifo_n < DEPTH);
      if (push)
        for (int c = 0; c < 3; c++)
          exp_q.push_back({gray_last_i && (c == 2), 2'(c), gray_data_i});
      fifo_n = fifo_n + int'(push) - int'(pop);
      held   = pop ? 1'b1 : (b_acc ? 1'b0 : held);
    end
  end

  // drivers
  task automatic push_px(input logic [CW-1:0] d, input logic l);
    int n = 0;
    gray_valid_i = 1'b1;
    gray_data_i  = d;
    gray_last_i  = l;
    while (1) begin
      @(negedge clk);
      if (gray_ready_o) break;
      n++;
      if (n > 200) begin
        check("push_timeout", n, 0);
        break;
      end
    end
    @(posedge clk); #1;
    gray_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  logic [9:0] bp_tab [6] = '{ {2'd0, 8'h10}, {2'd1, 8'h10}, {2'd2, 8'h10},
                              {2'd0, 8'h20}, {2'd1, 8'h20}, {2'd2, 8'h20} };

  initial begin
    int n;
    int n_acc;
    rst_i = 1'b0; clear_i = 1'b0;
    gray_valid_i = 1'b0; gray_data_i = '0; gray_last_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;

    // reset state
    @(negedge clk);
    check("rst_valid", rgb_valid_o, 0);
    check("rst_data", rgb_data_o, 0);
    check("rst_channel", rgb_channel_o, 0);
    check("rst_last", rgb_last_o, 0);
    check("rst_count", pix_count_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_ready", gray_ready_o, 1);
    @(posedge clk); #1;

    // single pixel: first beat two cycles after accept
    ready_fix = 1'b1;
    push_px(8'h5A, 1'b0);
    @(negedge clk); check("sp_no_bypass", rgb_valid_o, 0);
    @(negedge clk); check("sp_r", {rgb_valid_o, rgb_last_o, rgb_channel_o, rgb_data_o}, {1'b1, 1'b0, 2'd0, 8'h5A});
    @(negedge clk); check("sp_g", {rgb_valid_o, rgb_last_o, rgb_channel_o, rgb_data_o}, {1'b1, 1'b0, 2'd1, 8'h5A});
    @(negedge clk); check("sp_b", {rgb_valid_o, rgb_last_o, rgb_channel_o, rgb_data_o}, {1'b1, 1'b0, 2'd2, 8'h5A});
    @(negedge clk); check("sp_idle", rgb_valid_o, 0);
    check("sp_count", pix_count_o, 1);
    @(posedge clk); #1;

    // back-pressure with ready pattern 1,0,0
    obs_q.delete();
    rec_en = 1; pat_i = 0; ready_mode = 2;
    push_px(8'h10, 1'b0);
    push_px(8'h20, 1'b0);
    n = 0;
    while (obs_q.size() < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    rec_en = 0;
    check("bp_count", obs_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check("bp_seq", (i < obs_q.size()) ? obs_q[i] : 10'h3FF, bp_tab[i]);
    ready_mode = 0; ready_fix = 1'b1;
    wait_drain();

    // full FIFO: 4 buffered plus 1 in the output register
    ready_fix = 1'b0;
    n_acc = 0;
    gray_valid_i = 1'b1; gray_data_i = 8'h30; gray_last_i = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (gray_ready_o) n_acc++;
      @(posedge clk); #1;
      gray_data_i = 8'h30 + 8'(n_acc);
      if (n_acc >= 6) gray_valid_i = 1'b0;
    end
    gray_valid_i = 1'b0;
    check("full_accepts", n_acc, 5);
    check("full_ready_low", gray_ready_o, 0);
    ready_fix = 1'b1;
    @(negedge clk); check("full_r", {rgb_channel_o, rgb_data_o}, {2'd0, 8'h30});
    @(negedge clk); check("full_g", {rgb_channel_o, rgb_data_o}, {2'd1, 8'h30});
    @(negedge clk); check("full_b", {rgb_channel_o, rgb_data_o}, {2'd2, 8'h30});
    check("full_ready_at_b", gray_ready_o, 0);
    @(negedge clk); check("full_ready_rise", gray_ready_o, 1);
    @(posedge clk); #1;
    wait_drain();

    // frame end
    done_pulses = 0; last_beats = 0; rec_en = 1;
    push_px(8'hA1, 1'b0);
    push_px(8'hA2, 1'b0);
    push_px(8'hA3, 1'b1);
    wait_drain();
    repeat (3) @(negedge clk);
    rec_en = 0;
    check("fe_done_pulses", done_pulses, 1);
    check("fe_last_beats", last_beats, 1);
    check("fe_last_beat", last_beat_seen, {1'b1, 2'd2, 8'hA3});
    check("fe_count", pix_count_o, 0);
    @(posedge clk); #1;

    // clear during a G beat with two pixels queued
    ready_fix = 1'b0;
    push_px(8'h40, 1'b0);
    push_px(8'h41, 1'b0);
    push_px(8'h42, 1'b0);
    ready_fix = 1'b1;
    @(posedge clk); #1;
    ready_fix = 1'b0;
    @(negedge clk); check("clr_in_g", {rgb_valid_o, rgb_channel_o, rgb_data_o}, {1'b1, 2'd1, 8'h40});
    @(posedge clk); #1;
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    @(negedge clk);
    check("clr_valid", rgb_valid_o, 0);
    check("clr_count", pix_count_o, 0);
    check("clr_ready", gray_ready_o, 1);
    @(posedge clk); #1;
    ready_fix = 1'b1;
    push_px(8'hFF, 1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rgb_valid_o && n < 10);
    check("clr_after_r", {rgb_valid_o, rgb_channel_o, rgb_data_o}, {1'b1, 2'd0, 8'hFF});
    @(posedge clk); #1;
    wait_drain();

    // randomized traffic
    ready_mode = 1;
    repeat (300) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      if ($urandom_range(0, 99) == 0) begin
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
      end
      push_px(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
    end
    ready_mode = 0; ready_fix = 1'b1;
    wait_drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray2rgb_serializer.md
Name: gray2rgb_serializer

Overview:
- Output-side counterpart of the RGB-to-gray front end in the edge-detection pipeline.
- Accepts filtered gray pixels over a valid/ready stream and buffers them in a small FIFO.
- Re-expands each gray pixel into three sequential colour-channel beats (R, G, B), each carrying the gray value, for the Avalon write-back path.
- Tracks pixels emitted per frame and flags frame completion.

Parameters:
- COLOR_SIZE, 8, bits per colour channel / gray pixel
- FIFO_DEPTH, 4, input buffer entries; power of two, >= 2
- CNT_W, 16, width of the per-frame pixel counter

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous reset, active-low (0 = reset)
- clear_i  in  1  synchronous flush, active-high
- gray_valid_i  in  1  input pixel valid
- gray_ready_o  out  1  input ready (FIFO not full)
- gray_data_i  in  COLOR_SIZE  gray pixel
- gray_last_i  in  1  marks last pixel of a frame
- rgb_valid_o  out  1  output beat valid
- rgb_ready_i  in  1  downstream ready
- rgb_data_o  out  COLOR_SIZE  channel value
- rgb_channel_o  out  2  0=R, 1=G, 2=B; 3 never driven
- rgb_last_o  out  1  high on the B beat of a last-tagged pixel
- pix_count_o  out  CNT_W  pixels fully emitted in the current frame
- frame_done_o  out  1  one-cycle pulse after the final B beat of a frame

Behaviour:
- Reset (rst_i==0 at an edge):
  - FIFO emptied; FSM to IDLE.
  - rgb_valid_o=0, rgb_data_o=0, rgb_channel_o=0, rgb_last_o=0, pix_count_o=0, frame_done_o=0.
  - gray_ready_o=1 from the first cycle after reset.
  - Reset has priority over clear_i; effective mid-beat, and a held beat is dropped.
- clear_i: same effect as reset except it is active-high; priority over all handshakes.
- Input handshake:
  - Push when gray_valid_i && gray_ready_o.
  - gray_ready_o = !full, combinational from registered FIFO count.
  - When full, no push occurs even if a pop happens in the same cycle; the slot frees on the next cycle.
  - Each entry stores {last, data}.
- FSM states: IDLE, CH_R, CH_G, CH_B.
  - IDLE -> CH_R when the FIFO is non-empty: pop the head, load the output register.
  - CH_R -> CH_G and CH_G -> CH_B on rgb_valid_o && rgb_ready_i.
  - CH_B on accept: if FIFO non-empty, pop and go directly to CH_R (no bubble); otherwise go to IDLE.
  - rgb_valid_o = 1 in CH_R, CH_G and CH_B.
  - rgb_data_o, rgb_channel_o and rgb_last_o are registered and held stable while valid && !ready.
- Latency and throughput:
  - A pixel accepted at edge k with the FIFO empty and FSM in IDLE gives rgb_valid_o=1 after edge k+1 (R beat).
  - Sustained throughput is one pixel per 3 cycles with rgb_ready_i=1.
- Simultaneous push and pop: both occur in the same cycle; the FIFO count is unchanged.
- Empty-FIFO push while IDLE: the pixel is not bypassed; it passes through the FIFO, which gives the 2-cycle latency above.
- Counter:
  - pix_count_o increments on each accepted B beat and wraps modulo 2^CNT_W.
  - On an accepted B beat with rgb_last_o=1: pix_count_o resets to 0 at that edge and frame_done_o=1 for the following cycle only.
- Pointer arithmetic: FIFO read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally; the count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package holds:
  - COLOR_SIZE default.
  - Channel encoding constants CH_R=2'd0, CH_G=2'd1, CH_B=2'd2.
  - FSM state encoding.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty, synchronous active-low reset plus clear), instantiated with width COLOR_SIZE+1.

Test Plan:
- Reset: rst_i=0 for 2 cycles, then 1 -> all outputs 0, gray_ready_o=1.
- Single pixel: push 0x5A with last=0, rgb_ready_i=1 -> beats (0x5A,ch0), (0x5A,ch1), (0x5A,ch2) on consecutive cycles, first beat 2 cycles after accept; pix_count_o=1.
- Back-pressure: push 0x10, 0x20; rgb_ready_i toggles 1,0,0,1,... -> rgb_data_o and rgb_channel_o stable while stalled; exact sequence 10/0, 10/1, 10/2, 20/0, 20/1, 20/2 with no gaps or repeats.
- Full FIFO: rgb_ready_i=0, push 6 pixels -> only 4 accepted into the FIFO plus 1 held in the output register; gray_ready_o=0 after the 5th accept; it rises one cycle after the first B-beat pop.
- Frame end: 3 pixels, third with last=1 -> rgb_last_o=1 only on the third pixel's B beat; frame_done_o pulses once; pix_count_o returns to 0.
- Mid-operation clear: assert clear_i during a G beat with 2 pixels queued -> next cycle rgb_valid_o=0, FIFO empty, pix_count_o=0; a subsequent push of 0xFF emits cleanly starting at ch0.
